// File: rtl/twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_sequencer
// Purpose  : Twiddle-number sequence for one R2^2 SDF butterfly stage, plus
//            valid/first/last/zero markers and a PIPE-deep tc_en/tc_last line.
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_sequencer #(
  parameter int LOG_N = 6,
  parameter int TW_FF = 1,
  parameter int TC_FF = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             di_en,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_en,
  output logic             tw_first,
  output logic             tw_last,
  output logic             tw_zero,
  output logic             tc_en,
  output logic             tc_last,
  output logic [LOG_N-1:0] idx
);

  localparam int               PIPE    = TW_FF + TC_FF;
  localparam logic [LOG_N-1:0] CNT_MAX = '1;

  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic [LOG_N-1:0] tw_addr_q;
  logic             tw_en_q, tw_first_q, tw_last_q, tw_zero_q;
  logic [1:0]       quad;
  logic [LOG_N-1:0] mult, offs, tw_num;
  logic             accept;

  // Multiplier is the bit-reversed quadrant: 0,1,2,3 -> 0,2,1,3.
  always_comb begin
    quad   = cnt_q[LOG_N-1 -: 2];
    mult   = {{(LOG_N-2){1'b0}}, quad[0], quad[1]};
    offs   = {2'b00, cnt_q[LOG_N-3:0]};
    tw_num = offs * mult;
  end

  assign accept = di_en & ~clear;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      tw_addr_q  <= '0;
      tw_en_q    <= 1'b0;
      tw_first_q <= 1'b0;
      tw_last_q  <= 1'b0;
      tw_zero_q  <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      tw_en_q    <= accept;
      tw_first_q <= accept && (cnt_q == '0);
      tw_last_q  <= accept && (cnt_q == CNT_MAX);
      // Address and zero hint hold through gaps and clear.
      if (accept) begin
        tw_addr_q <= tw_num;
        tw_zero_q <= (tw_num == '0);
      end
    end
  end

  generate
    if (PIPE == 0) begin : g_pipe_none
      assign tc_en   = tw_en_q;
      assign tc_last = tw_last_q;
    end else begin : g_pipe
      logic [PIPE-1:0] en_q, last_q;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          en_q   <= '0;
          last_q <= '0;
        end else if (clear) begin
          en_q   <= '0;
          last_q <= '0;
        end else begin
          en_q[0]   <= tw_en_q;
          last_q[0] <= tw_last_q;
          for (int k = 1; k < PIPE; k++) begin
            en_q[k]   <= en_q[k-1];
            last_q[k] <= last_q[k-1];
          end
        end
      end

      assign tc_en   = en_q[PIPE-1];
      assign tc_last = last_q[PIPE-1];
    end
  endgenerate

  assign tw_addr  = tw_addr_q;
  assign tw_en    = tw_en_q;
  assign tw_first = tw_first_q;
  assign tw_last  = tw_last_q;
  assign tw_zero  = tw_zero_q;
  assign idx      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_sequencer
// Purpose  : Directed checks of twiddle_sequencer (N=16) with PIPE 0/1/2 copies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_sequencer;

  logic clock = 1'b0;
  logic reset_n, clear, di_en;

  logic [3:0] tw_addr, idx;
  logic       tw_en, tw_first, tw_last, tw_zero, tc_en, tc_last;

  logic [3:0] a00_addr, a10_addr, a01_addr, i00, i10, i01;
  logic       e00, f00, l00, z00, tce00, tcl00;
  logic       e10, f10, l10, z10, tce10, tcl10;
  logic       e01, f01, l01, z01, tce01, tcl01;

  int n_assert = 0;
  int n_fail   = 0;

  // Hand-computed twiddle numbers for indices 0..15 at N=16.
  logic [3:0] TBL [16] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2, 4'd4, 4'd6,
                           4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd3, 4'd6, 4'd9};

  logic [3:0] m_cnt, m_addr;
  logic       m_first, m_zero;
  logic [2:0] h_en, h_last;

  always #5 clock = ~clock;

  twiddle_sequencer #(.LOG_N(4), .TW_FF(1), .TC_FF(1)) u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .di_en(di_en),
    .tw_addr(tw_addr), .tw_en(tw_en), .tw_first(tw_first), .tw_last(tw_last),
    .tw_zero(tw_zero), .tc_en(tc_en), .tc_last(tc_last), .idx(idx));

  twiddle_sequencer #(.LOG_N(4), .TW_FF(0), .TC_FF(0)) u_p00 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .di_en(di_en),
    .tw_addr(a00_addr), .tw_en(e00), .tw_first(f00), .tw_last(l00),
    .tw_zero(z00), .tc_en(tce00), .tc_last(tcl00), .idx(i00));

  twiddle_sequencer #(.LOG_N(4), .TW_FF(1), .TC_FF(0)) u_p10 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .di_en(di_en),
    .tw_addr(a10_addr), .tw_en(e10), .tw_first(f10), .tw_last(l10),
    .tw_zero(z10), .tc_en(tce10), .tc_last(tcl10), .idx(i10));

  twiddle_sequencer #(.LOG_N(4), .TW_FF(0), .TC_FF(1)) u_p01 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .di_en(di_en),
    .tw_addr(a01_addr), .tw_en(e01), .tw_first(f01), .tw_last(l01),
    .tw_zero(z01), .tc_en(tce01), .tc_last(tcl01), .idx(i01));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 4'd0; m_addr = 4'd0; m_first = 1'b0; m_zero = 1'b1;
    h_en = 3'b000; h_last = 3'b000;
  endtask

  task automatic check_all();
    chk("idx",      {28'd0, idx},     {28'd0, m_cnt});
    chk("tw_addr",  {28'd0, tw_addr}, {28'd0, m_addr});
    chk("tw_en",    {31'd0, tw_en},   {31'd0, h_en[0]});
    chk("tw_first", {31'd0, tw_first},{31'd0, m_first});
    chk("tw_last",  {31'd0, tw_last}, {31'd0, h_last[0]});
    chk("tw_zero",  {31'd0, tw_zero}, {31'd0, m_zero});
    chk("tc_en_p2", {31'd0, tc_en},   {31'd0, h_en[2]});
    chk("tc_last_p2", {31'd0, tc_last}, {31'd0, h_last[2]});
    chk("tc_en_p00", {31'd0, tce00},  {31'd0, h_en[0]});
    chk("tc_en_p10", {31'd0, tce10},  {31'd0, h_en[1]});
    chk("tc_en_p01", {31'd0, tce01},  {31'd0, h_en[1]});
    chk("tc_last_p10", {31'd0, tcl10}, {31'd0, h_last[1]});
  endtask

  // Called at a falling edge: drive inputs, cross one rising edge, update model, check.
  task automatic tick(input logic en, input logic clr);
    di_en = en; clear = clr;
    @(negedge clock);
    if (clr) begin
      m_cnt = 4'd0; m_first = 1'b0;
      h_en = 3'b000; h_last = 3'b000;
    end else if (en) begin
      m_addr  = TBL[m_cnt];
      m_zero  = (TBL[m_cnt] == 4'd0);
      m_first = (m_cnt == 4'd0);
      h_en    = {h_en[1:0], 1'b1};
      h_last  = {h_last[1:0], (m_cnt == 4'd15)};
      m_cnt   = m_cnt + 4'd1;
    end else begin
      m_first = 1'b0;
      h_en    = {h_en[1:0], 1'b0};
      h_last  = {h_last[1:0], 1'b0};
    end
    check_all();
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; di_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    chk("rst_zero", {31'd0, tw_zero}, 32'd1);
    reset_n = 1'b1;

    // 16 back-to-back samples from reset
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, 1'b0);
      chk("b2b_addr", {28'd0, tw_addr}, {28'd0, TBL[k]});
      if (k == 0)  chk("b2b_first", {31'd0, tw_first}, 32'd1);
      if (k == 15) chk("b2b_last",  {31'd0, tw_last},  32'd1);
    end
    repeat (3) tick(1'b0, 1'b0);

    // Alternating di_en; frame position preserved across gaps
    for (int k = 0; k < 32; k++) begin
      tick((k % 2) == 0, 1'b0);
      if ((k % 2) == 0) chk("alt_addr", {28'd0, tw_addr}, {28'd0, TBL[k/2]});
    end
    repeat (3) tick(1'b0, 1'b0);

    // 40 continuous samples across a frame wrap
    tick(1'b0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      tick(1'b1, 1'b0);
      if (k == 16) begin
        chk("wrap_addr16",  {28'd0, tw_addr}, 32'd0);
        chk("wrap_first16", {31'd0, tw_first}, 32'd1);
      end
      if (k == 31) begin
        chk("wrap_addr31", {28'd0, tw_addr}, 32'd9);
        chk("wrap_last31", {31'd0, tw_last}, 32'd1);
      end
    end

    // clear together with di_en at cnt=6
    tick(1'b0, 1'b1);
    repeat (6) tick(1'b1, 1'b0);
    chk("pre_clear_idx", {28'd0, idx}, 32'd6);
    tick(1'b1, 1'b1);
    chk("clr_tw_en", {31'd0, tw_en}, 32'd0);
    chk("clr_idx",   {28'd0, idx},   32'd0);
    chk("clr_tc_en", {31'd0, tc_en}, 32'd0);
    tick(1'b1, 1'b0);
    chk("post_clr_addr",  {28'd0, tw_addr}, 32'd0);
    chk("post_clr_first", {31'd0, tw_first}, 32'd1);
    chk("post_clr_tc_en", {31'd0, tc_en}, 32'd0);
    repeat (3) tick(1'b0, 1'b0);

    // Asynchronous reset mid-cycle at cnt=10 while streaming
    tick(1'b0, 1'b1);
    repeat (10) tick(1'b1, 1'b0);
    di_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_en",   {31'd0, tw_en},   32'd0);
    chk("arst_idx",  {28'd0, idx},     32'd0);
    chk("arst_zero", {31'd0, tw_zero}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    tick(1'b1, 1'b0);
    chk("arst_first_addr", {28'd0, tw_addr}, 32'd0);
    chk("arst_first",      {31'd0, tw_first}, 32'd1);
    repeat (3) tick(1'b1, 1'b0);
    chk("arst_tc_after", {31'd0, tc_en}, 32'd1);

    // Random di_en with occasional clear
    for (int k = 0; k < 1000; k++) begin
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
      chk("addr_range", {31'd0, (tw_addr < 4'd12)}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
